// File: rtl/sc_regshifter_seq.sv
`default_nettype none
// ============================================================================
// Module   : sc_regshifter_seq
// Brief    : Sequential shifter that shifts or rotates one bit position per
//            clock, for a requested amount, with busy/done handshake.
//            Define SC_REGSHIFTER_ROTATE_EN to make mode 11 a rotate-left;
//            without it, mode 11 behaves as a logical shift left.
// Revision : 1.0 - initial release
// ============================================================================
module sc_regshifter_seq #(
    parameter int RegSHIFTER_DATAWIDTH   = 8,
    parameter int RegSHIFTER_AMOUNTWIDTH = 3
) (
    input  logic                              SC_RegSHIFTERSEQ_CLOCK_50,
    input  logic                              SC_RegSHIFTERSEQ_RESET_InHigh,
    input  logic                              SC_RegSHIFTERSEQ_start_In,
    input  logic [1:0]                        SC_RegSHIFTERSEQ_mode_In,
    input  logic [RegSHIFTER_AMOUNTWIDTH-1:0] SC_RegSHIFTERSEQ_amount_In,
    input  logic [RegSHIFTER_DATAWIDTH-1:0]   SC_RegSHIFTERSEQ_data_InBUS,
    output logic [RegSHIFTER_DATAWIDTH-1:0]   SC_RegSHIFTERSEQ_data_OutBUS,
    output logic                              SC_RegSHIFTERSEQ_carry_Out,
    output logic                              SC_RegSHIFTERSEQ_busy_Out,
    output logic                              SC_RegSHIFTERSEQ_done_Out
);

    localparam int W = RegSHIFTER_DATAWIDTH;

    localparam logic [1:0] c_STATE_IDLE  = 2'd0;
    localparam logic [1:0] c_STATE_SHIFT = 2'd1;
    localparam logic [1:0] c_STATE_DONE  = 2'd2;

    localparam logic [1:0] c_MODE_SRL = 2'b01;
    localparam logic [1:0] c_MODE_SRA = 2'b10;
`ifdef SC_REGSHIFTER_ROTATE_EN
    localparam logic [1:0] c_MODE_ROL = 2'b11;
`endif

    localparam logic [RegSHIFTER_AMOUNTWIDTH-1:0] c_COUNT_ONE  = RegSHIFTER_AMOUNTWIDTH'(1);
    localparam logic [RegSHIFTER_AMOUNTWIDTH-1:0] c_COUNT_ZERO = '0;

    logic [1:0]                        r_state;
    logic [1:0]                        r_mode;
    logic [RegSHIFTER_AMOUNTWIDTH-1:0] r_count;
    logic [W-1:0]                      r_data;
    logic                              r_carry;
    logic                              r_done;

    logic [W-1:0]                      w_shiftData;
    logic                              w_shiftCarry;

    // One-position step of the working register for the latched mode.
    always_comb begin
        w_shiftData  = {r_data[W-2:0], 1'b0};
        w_shiftCarry = r_data[W-1];
        case (r_mode)
            c_MODE_SRL: begin
                w_shiftData  = {1'b0, r_data[W-1:1]};
                w_shiftCarry = r_data[0];
            end
            c_MODE_SRA: begin
                w_shiftData  = {r_data[W-1], r_data[W-1:1]};
                w_shiftCarry = r_data[0];
            end
`ifdef SC_REGSHIFTER_ROTATE_EN
            c_MODE_ROL: begin
                w_shiftData  = {r_data[W-2:0], r_data[W-1]};
                w_shiftCarry = r_data[W-1];
            end
`endif
            default: begin
                w_shiftData  = {r_data[W-2:0], 1'b0};
                w_shiftCarry = r_data[W-1];
            end
        endcase
    end

    always_ff @(posedge SC_RegSHIFTERSEQ_CLOCK_50) begin
        if (SC_RegSHIFTERSEQ_RESET_InHigh) begin
            r_state <= c_STATE_IDLE;
            r_mode  <= 2'b00;
            r_count <= c_COUNT_ZERO;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_STATE_IDLE: begin
                    if (SC_RegSHIFTERSEQ_start_In) begin
                        r_data  <= SC_RegSHIFTERSEQ_data_InBUS;
                        r_mode  <= SC_RegSHIFTERSEQ_mode_In;
                        r_count <= SC_RegSHIFTERSEQ_amount_In;
                        r_carry <= 1'b0;
                        if (SC_RegSHIFTERSEQ_amount_In == c_COUNT_ZERO) begin
                            r_state <= c_STATE_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_STATE_SHIFT;
                        end
                    end
                end
                c_STATE_SHIFT: begin
                    r_data  <= w_shiftData;
                    r_carry <= w_shiftCarry;
                    r_count <= r_count - c_COUNT_ONE;
                    if (r_count == c_COUNT_ONE) begin
                        r_state <= c_STATE_DONE;
                        r_done  <= 1'b1;
                    end
                end
                c_STATE_DONE: begin
                    r_state <= c_STATE_IDLE;
                end
                default: begin
                    r_state <= c_STATE_IDLE;
                end
            endcase
        end
    end

    assign SC_RegSHIFTERSEQ_data_OutBUS = r_data;
    assign SC_RegSHIFTERSEQ_carry_Out   = r_carry;
    assign SC_RegSHIFTERSEQ_busy_Out    = (r_state != c_STATE_IDLE);
    assign SC_RegSHIFTERSEQ_done_Out    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sc_regshifter_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_regshifter_seq
// Brief    : Directed self-checking bench for sc_regshifter_seq (8-bit data,
//            3-bit amount); mode 11 expectation follows SC_REGSHIFTER_ROTATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_regshifter_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [2:0] amount;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic       carry;
    logic       busy;
    logic       done;

    int nCompared   = 0;
    int nMismatched = 0;

    sc_regshifter_seq #(
        .RegSHIFTER_DATAWIDTH   (8),
        .RegSHIFTER_AMOUNTWIDTH (3)
    ) dut (
        .SC_RegSHIFTERSEQ_CLOCK_50     (clk),
        .SC_RegSHIFTERSEQ_RESET_InHigh (rst),
        .SC_RegSHIFTERSEQ_start_In     (start),
        .SC_RegSHIFTERSEQ_mode_In      (mode),
        .SC_RegSHIFTERSEQ_amount_In    (amount),
        .SC_RegSHIFTERSEQ_data_InBUS   (dataIn),
        .SC_RegSHIFTERSEQ_data_OutBUS  (dataOut),
        .SC_RegSHIFTERSEQ_carry_Out    (carry),
        .SC_RegSHIFTERSEQ_busy_Out     (busy),
        .SC_RegSHIFTERSEQ_done_Out     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request from a negedge; returns the cycle (counted from the
    // start-sampling edge) in which done was seen, or >20 on timeout.
    task automatic do_op(input logic [1:0] m, input logic [2:0] a,
                         input logic [7:0] d, output int lat);
        mode   = m;
        amount = a;
        dataIn = d;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat <= 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nCompared++;
        if ({dataOut, carry, busy, done} !== 11'b0) begin
            nMismatched++;
            $display("FAIL reset: data=%h carry=%b busy=%b done=%b required 00/0/0/0",
                     dataOut, carry, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sll();
        mode = 2'b00; amount = 3'd3; dataIn = 8'h96; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            nCompared++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                nMismatched++;
                $display("FAIL sll_busy cycle %0d: busy=%b done=%b required 1/0", c, busy, done);
            end
            @(negedge clk);
        end
        nCompared++;
        if (done !== 1'b1 || dataOut !== 8'hB0 || carry !== 1'b0) begin
            nMismatched++;
            $display("FAIL sll_result: done=%b data=%h carry=%b required 1/b0/0", done, dataOut, carry);
        end
        @(negedge clk);
        nCompared++;
        if (done !== 1'b0 || busy !== 1'b0 || dataOut !== 8'hB0) begin
            nMismatched++;
            $display("FAIL sll_after: done=%b busy=%b data=%h required 0/0/b0", done, busy, dataOut);
        end
    endtask

    task automatic test_right_shifts();
        int lat;
        do_op(2'b10, 3'd2, 8'h96, lat);
        nCompared++;
        if (lat != 3 || dataOut !== 8'hE5 || carry !== 1'b1) begin
            nMismatched++;
            $display("FAIL sra: lat=%0d data=%h carry=%b required 3/e5/1", lat, dataOut, carry);
        end
        @(negedge clk);
        do_op(2'b01, 3'd2, 8'h96, lat);
        nCompared++;
        if (lat != 3 || dataOut !== 8'h25 || carry !== 1'b1) begin
            nMismatched++;
            $display("FAIL srl: lat=%0d data=%h carry=%b required 3/25/1", lat, dataOut, carry);
        end
        @(negedge clk);
        do_op(2'b10, 3'd7, 8'h80, lat);
        nCompared++;
        if (lat != 8 || dataOut !== 8'hFF || carry !== 1'b0) begin
            nMismatched++;
            $display("FAIL sra_max: lat=%0d data=%h carry=%b required 8/ff/0", lat, dataOut, carry);
        end
        @(negedge clk);
        do_op(2'b01, 3'd7, 8'hC3, lat);
        nCompared++;
        if (lat != 8 || dataOut !== 8'h01 || carry !== 1'b1) begin
            nMismatched++;
            $display("FAIL srl_max: lat=%0d data=%h carry=%b required 8/01/1", lat, dataOut, carry);
        end
        @(negedge clk);
    endtask

    task automatic test_mode3();
        int lat;
        logic [7:0] expData;
`ifdef SC_REGSHIFTER_ROTATE_EN
        expData = 8'h03;
`else
        expData = 8'h02;
`endif
        do_op(2'b11, 3'd1, 8'h81, lat);
        nCompared++;
        if (lat != 2 || dataOut !== expData || carry !== 1'b1) begin
            nMismatched++;
            $display("FAIL mode3: lat=%0d data=%h carry=%b required 2/%h/1", lat, dataOut, carry, expData);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_amount();
        int lat;
        do_op(2'b00, 3'd0, 8'h5A, lat);
        nCompared++;
        if (lat != 1 || dataOut !== 8'h5A || carry !== 1'b0) begin
            nMismatched++;
            $display("FAIL zero_amount: lat=%0d data=%h carry=%b required 1/5a/0", lat, dataOut, carry);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int lat;
        mode = 2'b00; amount = 3'd3; dataIn = 8'h96; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mode = 2'b01; amount = 3'd1; dataIn = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (done !== 1'b1 && lat <= 20) begin
            @(negedge clk);
            lat++;
        end
        nCompared++;
        if (lat != 4 || dataOut !== 8'hB0 || carry !== 1'b0) begin
            nMismatched++;
            $display("FAIL ignore_start: lat=%0d data=%h carry=%b required 4/b0/0", lat, dataOut, carry);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(2'b01, 3'd2, 8'h96, lat);
        // Request held through DONE: only the following IDLE edge may take it.
        mode = 2'b00; amount = 3'd1; dataIn = 8'h5A; start = 1'b1;
        @(negedge clk);
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0 || dataOut !== 8'h25 || carry !== 1'b1) begin
            nMismatched++;
            $display("FAIL b2b_idle: busy=%b done=%b data=%h carry=%b required 0/0/25/1",
                     busy, done, dataOut, carry);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat <= 20) begin
            @(negedge clk);
            lat++;
        end
        nCompared++;
        if (lat != 2 || dataOut !== 8'hB4 || carry !== 1'b0) begin
            nMismatched++;
            $display("FAIL b2b_second: lat=%0d data=%h carry=%b required 2/b4/0", lat, dataOut, carry);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        int doneSeen;
        mode = 2'b10; amount = 3'd5; dataIn = 8'h96; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        nCompared++;
        if (dataOut !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || carry !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_mid: data=%h busy=%b done=%b carry=%b required 00/0/0/0",
                     dataOut, busy, done, carry);
        end
        rst = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        nCompared++;
        if (doneSeen != 0) begin
            nMismatched++;
            $display("FAIL reset_mid_quiet: activity cycles=%0d required 0", doneSeen);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'b00; amount = 3'd0; dataIn = 8'h00;
        @(negedge clk);
        test_reset();
        test_sll();
        test_right_shifts();
        test_mode3();
        test_zero_amount();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
